// File: rtl/td4_sequencer_if.sv
// Bus between the TD4 sequencer and its ROM/datapath: run/step control,
// instruction fetch, carry feedback and the decoded datapath controls.
interface td4_sequencer_if;
    logic       run;
    logic       step;
    logic [7:0] rom_data;
    logic       carry_in;
    logic [3:0] rom_addr;
    logic [3:0] im;
    logic [1:0] sel;
    logic       load_a_n;
    logic       load_b_n;
    logic       load_out_n;
    logic       c_flag;
    logic [1:0] state;
    logic       retire;

    modport master (
        input  run, step, rom_data, carry_in,
        output rom_addr, im, sel, load_a_n, load_b_n, load_out_n, c_flag, state, retire
    );

    modport slave (
        output run, step, rom_data, carry_in,
        input  rom_addr, im, sel, load_a_n, load_b_n, load_out_n, c_flag, state, retire
    );
endinterface

// File: rtl/td4_sequencer.sv
// TD4 control sequencer: IDLE/FETCH/EXEC FSM, program counter, instruction
// register and carry flag, with a combinational EXEC-only datapath decode.
module td4_sequencer (
    input  logic            clk_i,
    input  logic            clr_ni,
    td4_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       c_flag_q, c_flag_d;
    logic       step_q;

    logic [3:0] opcode;
    logic       step_rise;
    logic       op_defined;
    logic       jump_taken;
    logic [1:0] sel;
    logic       load_a_n, load_b_n, load_out_n;

    assign opcode    = ir_q[7:4];
    assign step_rise = bus.step & ~step_q;

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q  <= IDLE;
            pc_q     <= 4'd0;
            ir_q     <= 8'd0;
            c_flag_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            c_flag_q <= c_flag_d;
            step_q   <= bus.step;
        end
    end

    // A STEP edge only matters in IDLE; elsewhere it is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.run || step_rise) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = bus.run ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (opcode)
            4'b1000, 4'b1010, 4'b1100, 4'b1101: op_defined = 1'b0;
            default:                            op_defined = 1'b1;
        endcase
    end

    // JNC looks at the flag as it stood before this instruction updates it.
    assign jump_taken = (opcode == 4'b1111) || ((opcode == 4'b1110) && !c_flag_q);

    always_comb begin
        ir_d     = ir_q;
        pc_d     = pc_q;
        c_flag_d = c_flag_q;
        if (state_q == FETCH) begin
            ir_d = bus.rom_data;
        end
        if (state_q == EXEC) begin
            pc_d = jump_taken ? ir_q[3:0] : pc_q + 4'd1;
            if (op_defined) begin
                c_flag_d = bus.carry_in;
            end
        end
    end

    always_comb begin
        sel        = 2'b11;
        load_a_n   = 1'b1;
        load_b_n   = 1'b1;
        load_out_n = 1'b1;
        if (state_q == EXEC) begin
            case (opcode)
                4'b0000: begin sel = 2'b00; load_a_n   = 1'b0; end
                4'b0101: begin sel = 2'b01; load_b_n   = 1'b0; end
                4'b0011: begin sel = 2'b11; load_a_n   = 1'b0; end
                4'b0111: begin sel = 2'b11; load_b_n   = 1'b0; end
                4'b0001: begin sel = 2'b01; load_a_n   = 1'b0; end
                4'b0100: begin sel = 2'b00; load_b_n   = 1'b0; end
                4'b0010: begin sel = 2'b10; load_a_n   = 1'b0; end
                4'b0110: begin sel = 2'b10; load_b_n   = 1'b0; end
                4'b1001: begin sel = 2'b01; load_out_n = 1'b0; end
                4'b1011: begin sel = 2'b11; load_out_n = 1'b0; end
                default: sel = 2'b11;
            endcase
        end
    end

    assign bus.rom_addr   = pc_q;
    assign bus.im         = ir_q[3:0];
    assign bus.sel        = sel;
    assign bus.load_a_n   = load_a_n;
    assign bus.load_b_n   = load_b_n;
    assign bus.load_out_n = load_out_n;
    assign bus.c_flag     = c_flag_q;
    assign bus.state      = state_q;
    assign bus.retire     = (state_q == EXEC);
endmodule

// File: tb/tb_td4_sequencer.sv
// Scoreboard bench for td4_sequencer: an instruction-level ISA model predicts
// each retired instruction; a monitor compares on every RETIRE cycle.
module tb_td4_sequencer;
    logic clk   = 1'b0;
    logic clr_n = 1'b1;

    td4_sequencer_if bus();

    td4_sequencer dut (
        .clk_i  (clk),
        .clr_ni (clr_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ROM and per-slot carry behave like the external datapath
    logic [7:0] rom [16];
    logic       carry_tab [16];
    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.carry_in = carry_tab[bus.rom_addr];

    typedef struct {
        logic [3:0] pc;
        logic [7:0] ir;
        logic       c_before;
        logic [1:0] sel;
        logic [2:0] strobes;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         n_retired = 0;
    int         phase_start = 0;
    logic [3:0] m_pc;
    logic       m_c;

    logic [1:0] sel_tab [16];
    int         dst_tab [16];
    bit         defined_tab [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic set_op(input int op, input logic [1:0] s, input int dst);
        sel_tab[op]     = s;
        dst_tab[op]     = dst;
        defined_tab[op] = 1'b1;
    endtask

    // ISA semantics: source selection, destination (1=A 2=B 3=OUT), branches, flag
    task automatic model_push(input int k);
        for (int i = 0; i < k; i++) begin
            exp_t       e;
            logic [3:0] op;
            e.pc       = m_pc;
            e.ir       = rom[m_pc];
            e.c_before = m_c;
            op         = e.ir[7:4];
            e.sel      = sel_tab[op];
            e.strobes  = 3'b111;
            if (dst_tab[op] != 0) e.strobes[dst_tab[op]-1] = 1'b0;
            sb_q.push_back(e);
            if (op == 4'hF || (op == 4'hE && !m_c)) m_pc = e.ir[3:0];
            else                                     m_pc = m_pc + 4'd1;
            if (defined_tab[op]) m_c = carry_tab[e.pc];
        end
    endtask

    always @(negedge clk) begin
        if (bus.retire === 1'b1) begin
            n_retired++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got retire at pc %0d, required none", bus.rom_addr);
            end else begin
                mon_e = sb_q.pop_front();
                $display("retire pc=%0d ir=%02h sel=%0d strobes=%03b c=%0b", bus.rom_addr, mon_e.ir,
                         bus.sel, {bus.load_out_n, bus.load_b_n, bus.load_a_n}, bus.c_flag);
                check("pc", bus.rom_addr, mon_e.pc);
                check("im", bus.im, mon_e.ir[3:0]);
                check("sel", bus.sel, mon_e.sel);
                check("strobes", {bus.load_out_n, bus.load_b_n, bus.load_a_n}, mon_e.strobes);
                check("c_before", bus.c_flag, mon_e.c_before);
                check("exec_state", bus.state, 2'b10);
            end
        end else begin
            check("idle_decode", {bus.sel, bus.load_out_n, bus.load_b_n, bus.load_a_n}, 5'b11111);
        end
    end

    task automatic wait_state(input logic [1:0] s);
        int t = 0;
        while (bus.state !== s && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_state", bus.state, s);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            rom[i]       = v;
            carry_tab[i] = 1'b0;
        end
    endtask

    task automatic do_reset(input bit full_check);
        clr_n    = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        #1;
        if (full_check) begin
            check("rst_state", bus.state, 2'b00);
            check("rst_pc", bus.rom_addr, 4'd0);
            check("rst_im", bus.im, 4'd0);
            check("rst_c", bus.c_flag, 1'b0);
            check("rst_outs", {bus.sel, bus.load_out_n, bus.load_b_n, bus.load_a_n, bus.retire}, 6'b111110);
        end
        m_pc = 4'd0;
        m_c  = 1'b0;
        sb_q.delete();
        @(posedge clk); #4;
        clr_n = 1'b1;
    endtask

    task automatic end_phase(input int k);
        repeat (2) @(posedge clk);
        #1;
        check("retire_count", n_retired - phase_start, k);
        check("sb_empty", sb_q.size(), 0);
        check("end_pc", bus.rom_addr, m_pc);
        check("end_c", bus.c_flag, m_c);
        check("end_state", bus.state, 2'b00);
    endtask

    // RUN held high for k instructions; RUN drops during FETCH or EXEC of the last one
    task automatic run_phase(input int k, input bit from_reset);
        int seen = 0;
        int busy = 0;
        int t    = 0;
        bit drop_in_fetch;
        drop_in_fetch = 1'($urandom_range(0, 1));
        phase_start   = n_retired;
        if (from_reset) begin
            clr_n = 1'b0;
            m_pc  = 4'd0;
            m_c   = 1'b0;
            sb_q.delete();
        end
        model_push(k);
        if (from_reset) begin
            bus.run = 1'b1;
            @(posedge clk); #4;
            clr_n = 1'b1;
            #1;
            check("release_idle", bus.state, 2'b00);
        end else begin
            @(posedge clk); #1;
            bus.run = 1'b1;
        end
        while (t < 200) begin
            @(posedge clk); #1;
            t++;
            if (bus.state != 2'b00) busy++;
            if (bus.state == 2'b10) seen++;
            if (bus.run && ((drop_in_fetch && bus.state == 2'b01 && seen == k - 1) ||
                            (bus.state == 2'b10 && seen == k)))
                bus.run = 1'b0;
            if (!bus.run && bus.state == 2'b00) break;
        end
        check("run_cycles", busy, 2 * k);
        end_phase(k);
    endtask

    // One STEP pulse per instruction; optionally a STEP edge planted inside EXEC
    task automatic step_phase(input int k, input bit force_ignore);
        phase_start = n_retired;
        bus.run     = 1'b0;
        model_push(k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            bus.step = 1'b1;
            wait_state(2'b01);
            if (force_ignore || $urandom_range(0, 1) == 1) begin
                bus.step = 1'b0;
                wait_state(2'b10);
                bus.step = 1'b1;
            end
            wait_state(2'b00);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            check("step_hold_idle", bus.state, 2'b00);
            bus.step = 1'b0;
        end
        end_phase(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            sel_tab[i]     = 2'b11;
            dst_tab[i]     = 0;
            defined_tab[i] = 1'b0;
        end
        set_op(4'h0, 2'b00, 1); set_op(4'h5, 2'b01, 2);
        set_op(4'h3, 2'b11, 1); set_op(4'h7, 2'b11, 2);
        set_op(4'h1, 2'b01, 1); set_op(4'h4, 2'b00, 2);
        set_op(4'h2, 2'b10, 1); set_op(4'h6, 2'b10, 2);
        set_op(4'h9, 2'b01, 3); set_op(4'hB, 2'b11, 3);
        set_op(4'hF, 2'b11, 0); set_op(4'hE, 2'b11, 0);

        fill_rom(8'h80);
        bus.run  = 1'b0;
        bus.step = 1'b0;
        #2;
        do_reset(1'b1);

        rom[0] = 8'h35;
        run_phase(1, 1'b1);
        check("mov_a5_pc", bus.rom_addr, 4'd1);

        fill_rom(8'h80);
        rom[0] = 8'h0F; carry_tab[0] = 1'b1;
        rom[1] = 8'hE7; carry_tab[1] = 1'b1;
        run_phase(2, 1'b1);
        check("jnc_not_taken_pc", bus.rom_addr, 4'd2);
        check("jnc_not_taken_c", bus.c_flag, 1'b1);
        carry_tab[0] = 1'b0;
        carry_tab[1] = 1'b0;
        run_phase(2, 1'b1);
        check("jnc_taken_pc", bus.rom_addr, 4'd7);

        fill_rom(8'h80);
        rom[0] = 8'h30; rom[1] = 8'h31; rom[2] = 8'h32; rom[3] = 8'hF0;
        run_phase(5, 1'b1);
        check("jmp_loop_pc", bus.rom_addr, 4'd1);

        fill_rom(8'h30);
        run_phase(16, 1'b1);
        check("pc_wrap", bus.rom_addr, 4'd0);

        fill_rom(8'h80);
        rom[0] = 8'h01; carry_tab[0] = 1'b1;
        rom[1] = 8'hA4;
        run_phase(2, 1'b1);
        check("nop_keeps_c", bus.c_flag, 1'b1);
        check("nop_pc", bus.rom_addr, 4'd2);

        do_reset(1'b0);
        fill_rom(8'h80);
        rom[0] = 8'h35; rom[1] = 8'h5A; rom[2] = 8'h9C;
        step_phase(3, 1'b1);
        check("step_pc", bus.rom_addr, 4'd3);

        fill_rom(8'h80);
        rom[0] = 8'h01; carry_tab[0] = 1'b1;
        rom[1] = 8'h93;
        run_phase(1, 1'b1);
        @(posedge clk); #1;
        bus.step = 1'b1;
        wait_state(2'b10);
        check("out_b_strobe", bus.load_out_n, 1'b0);
        #2;
        clr_n = 1'b0;
        #1;
        check("clr_out_strobe", bus.load_out_n, 1'b1);
        check("clr_pc", bus.rom_addr, 4'd0);
        check("clr_c", bus.c_flag, 1'b0);
        check("clr_state", bus.state, 2'b00);
        bus.step = 1'b0;
        m_pc = 4'd0;
        m_c  = 1'b0;
        sb_q.delete();
        @(posedge clk); #4;
        clr_n = 1'b1;

        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i]       = 8'($urandom);
                carry_tab[i] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) == 1)
                run_phase($urandom_range(1, 10), $urandom_range(0, 4) == 0);
            else
                step_phase($urandom_range(1, 4), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/td4_sequencer.md
TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: CLR  in  1  asynchronous active-low reset.
REQ-003 SHALL have: RUN  in  1  1 = continuous execution, 0 = halt after current instruction.
REQ-004 SHALL have: STEP  in  1  level input; a 0->1 transition sampled while halted executes exactly one instruction.
REQ-005 SHALL have: ROM_DATA  in  8  instruction word addressed by ROM_ADDR, [7:4] opcode, [3:0] immediate.
REQ-006 SHALL have: CARRY_IN  in  1  adder carry-out from the datapath.
REQ-007 SHALL have: ROM_ADDR  out  4  current PC.
REQ-008 SHALL have: IM  out  4  immediate field of the latched instruction (IR[3:0]).
REQ-009 SHALL have: SEL  out  2  datapath source: 00 A, 01 B, 10 IN port, 11 zero.
REQ-010 SHALL have: LOAD_A_N, LOAD_B_N, LOAD_OUT_N  out  1 each  active-low load strobes for the A, B and output registers.
REQ-011 SHALL have: C_FLAG  out  1  carry flag; STATE  out  2  FSM state; RETIRE  out  1  high in the EXEC cycle.

Function
REQ-012 SHALL implement FSM states IDLE=00, FETCH=01, EXEC=10; STATE output equals the current state.
REQ-013 IDLE -> FETCH when RUN=1 or a STEP rising edge is detected; otherwise stay in IDLE.
REQ-014 STEP edge detection SHALL use a registered copy of STEP; a STEP edge seen outside IDLE SHALL be discarded.
REQ-015 FETCH SHALL latch IR <= ROM_DATA and always go to EXEC the next cycle.
REQ-016 EXEC SHALL last exactly one cycle; at its closing edge go to FETCH if RUN=1, else go to IDLE.
REQ-017 SEL and LOAD_*_N SHALL be decoded combinationally from IR during EXEC only; outside EXEC, SEL=11 and all strobes are 1.
REQ-018 SHALL apply this decode (opcode -> SEL, strobe): 0000 ADD A,Im -> 00, A; 0101 ADD B,Im -> 01, B; 0011 MOV A,Im -> 11, A; 0111 MOV B,Im -> 11, B; 0001 MOV A,B -> 01, A; 0100 MOV B,A -> 00, B; 0010 IN A -> 10, A; 0110 IN B -> 10, B; 1001 OUT B -> 01, OUT; 1011 OUT Im -> 11, OUT; 1111 JMP -> 11, none; 1110 JNC -> 11, none.
REQ-019 At most one LOAD_*_N SHALL be low in any cycle, for exactly one EXEC cycle per instruction.
REQ-020 At the closing edge of EXEC, PC SHALL become IM for JMP, IM for JNC when C_FLAG=0, and PC+1 mod 16 otherwise (15 -> 0 wraps).
REQ-021 JNC SHALL test the C_FLAG value held before this instruction's own flag update.
REQ-022 At the closing edge of EXEC of every defined opcode, C_FLAG SHALL be set to CARRY_IN.
REQ-023 Undefined opcodes (1000, 1010, 1100, 1101) SHALL act as NOP: SEL=11, no strobe, C_FLAG unchanged, PC+1.
REQ-024 RUN falling during FETCH or EXEC SHALL NOT abort the instruction; the instruction completes, then the FSM enters IDLE.
REQ-025 ROM_ADDR SHALL equal PC at all times; PC changes only at the closing edge of EXEC.

Reset
REQ-026 CLR=0 SHALL immediately, independent of CLK, force STATE=IDLE, PC=0, IR=0, C_FLAG=0, STEP history=0, SEL=11, all LOAD_*_N=1 and RETIRE=0.
REQ-027 CLR asserted in any state, including mid-EXEC, SHALL suppress any pending strobe, PC update or flag update.
REQ-028 After CLR rises, the first state transition SHALL occur at the next rising CLK edge.

Verification
REQ-029 Reset, RUN=1, ROM[0]=0x35 (MOV A,5) -> FETCH, then EXEC with SEL=11, IM=5, LOAD_A_N=0, RETIRE=1; PC=1 afterward; 2 cycles per instruction.
REQ-030 ROM[0]=0x0F (ADD A,15) with CARRY_IN=1 in EXEC, ROM[1]=0xE7 (JNC 7) -> C_FLAG=1, JNC not taken, PC=2; the same sequence with CARRY_IN=0 -> PC=7.
REQ-031 ROM[3]=0xF0 (JMP 0) executed repeatedly -> PC sequence 0,1,2,3,0; sequential PC at 15 -> next PC 0.
REQ-032 RUN=0 with three STEP pulses -> exactly three instructions retire, with a RETIRE count of 3 and the FSM in IDLE; a STEP edge during EXEC is ignored.
REQ-033 CLR pulsed low mid-EXEC of 0x93 (OUT B) -> LOAD_OUT_N returns to 1 immediately, PC=0, C_FLAG=0, STATE=IDLE.
REQ-034 Undefined opcode 0xA4 with C_FLAG=1 -> no strobe, SEL=11, C_FLAG remains 1, PC increments.
